// File: rtl/lcd_bus_scheduler_if.sv
// Request/acknowledge ports of the two LCD writers plus the LCD pin bundle.
// The scheduler connects through the slave modport; a requester/pin model uses master.
interface lcd_bus_scheduler_if;
  logic       req0_valid;
  logic       req0_rs;
  logic [7:0] req0_data;
  logic       ack0;
  logic       req1_valid;
  logic       req1_rs;
  logic [7:0] req1_data;
  logic       ack1;
  logic       RS;
  logic       RW;
  logic       E;
  logic [7:0] data;
  logic       init_done;
  logic       busy;

  modport slave (
    input  req0_valid, req0_rs, req0_data, req1_valid, req1_rs, req1_data,
    output ack0, ack1, RS, RW, E, data, init_done, busy
  );

  modport master (
    output req0_valid, req0_rs, req0_data, req1_valid, req1_rs, req1_data,
    input  ack0, ack1, RS, RW, E, data, init_done, busy
  );
endinterface

// File: rtl/lcd_bus_scheduler.sv
// HD44780 8-bit bus sequencer: power-on init, then round-robin sharing of the bus
// between two write requesters, each byte strobed with programmable E timing.
module lcd_bus_scheduler #(
  parameter int T_PWR    = 1500000,
  parameter int T_SETUP  = 6,
  parameter int T_E_HIGH = 25,
  parameter int T_HOLD   = 2,
  parameter int T_CMD    = 4000,
  parameter int T_LONG   = 164000
) (
  input  logic               clk,
  input  logic               reset_n,
  lcd_bus_scheduler_if.slave bus
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_T = max2(max2(max2(T_PWR, T_SETUP), max2(T_E_HIGH, T_HOLD)),
                              max2(T_CMD, T_LONG));
  localparam int CW = $clog2(MAX_T) + 1;
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [2:0] {
    PWR_WAIT, INIT_LOAD, IDLE, SETUP, E_HIGH, HOLD, EXEC_WAIT
  } state_t;

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    init_idx;
  logic          last_port;
  logic          ack0_q, ack1_q, rs_q, e_q, done_q, busy_q;
  logic [7:0]    data_q;

  logic last_tick, grant0, grant1, grant_en, is_long;

  // NOTE: every signal gets a value on every path so always_comb never infers a latch.
  always_comb begin
    last_tick = (cnt == ONE);
    // last_port=1 means port 1 won last time, so port 0 takes a tie.
    grant0    = bus.req0_valid && (!bus.req1_valid || last_port);
    grant1    = bus.req1_valid && (!bus.req0_valid || !last_port);
    // A grant happens either in a quiet IDLE cycle or on the edge that enters IDLE,
    // so a waiting requester is acknowledged in the very first IDLE cycle.
    grant_en  = (state == IDLE && !ack0_q && !ack1_q) ||
                (state == EXEC_WAIT && last_tick && (done_q || init_idx == 2'd3));
    is_long   = !rs_q && (data_q inside {8'h01, 8'h02, 8'h03});
  end

  // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= PWR_WAIT;
      cnt       <= CW'(T_PWR);
      init_idx  <= 2'd0;
      last_port <= 1'b1;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      rs_q      <= 1'b0;
      e_q       <= 1'b0;
      data_q    <= 8'h00;
      done_q    <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state)
        PWR_WAIT: begin
          if (last_tick) begin
            state  <= INIT_LOAD;
            cnt    <= ONE;
            rs_q   <= 1'b0;
            data_q <= init_rom(init_idx);
          end else cnt <= cnt - ONE;
        end
        INIT_LOAD: begin
          state <= SETUP;
          cnt   <= CW'(T_SETUP);
        end
        IDLE: begin
          // The cycle carrying ack doubles as the load cycle for the granted byte.
          if (ack0_q || ack1_q) begin
            state  <= SETUP;
            cnt    <= CW'(T_SETUP);
            busy_q <= 1'b1;
          end
        end
        SETUP: begin
          if (last_tick) begin
            state <= E_HIGH;
            cnt   <= CW'(T_E_HIGH);
            e_q   <= 1'b1;
          end else cnt <= cnt - ONE;
        end
        E_HIGH: begin
          if (last_tick) begin
            state <= HOLD;
            cnt   <= CW'(T_HOLD);
            e_q   <= 1'b0;
          end else cnt <= cnt - ONE;
        end
        HOLD: begin
          if (last_tick) begin
            state <= EXEC_WAIT;
            cnt   <= is_long ? CW'(T_LONG) : CW'(T_CMD);
          end else cnt <= cnt - ONE;
        end
        EXEC_WAIT: begin
          if (last_tick) begin
            if (done_q || init_idx == 2'd3) begin
              state  <= IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state    <= INIT_LOAD;
              cnt      <= ONE;
              init_idx <= init_idx + 2'd1;
              rs_q     <= 1'b0;
              data_q   <= init_rom(init_idx + 2'd1);
            end
          end else cnt <= cnt - ONE;
        end
        default: state <= PWR_WAIT;
      endcase

      if (grant_en && (grant0 || grant1)) begin
        ack0_q    <= grant0;
        ack1_q    <= grant1;
        last_port <= grant1;
        rs_q      <= grant1 ? bus.req1_rs   : bus.req0_rs;
        data_q    <= grant1 ? bus.req1_data : bus.req0_data;
      end
    end
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.RS        = rs_q;
  assign bus.RW        = 1'b0;
  assign bus.E         = e_q;
  assign bus.data      = data_q;
  assign bus.init_done = done_q;
  assign bus.busy      = busy_q;

endmodule
